cpu_debug_mem_arbiter: RTL and testbench

Arbitrates the single-port debug-monitor RAM between two requesters: the JTAG debug path and the CPU's debug-memory Avalon slave. The JTAG path issues commands as `jdo` plus `take_*_ocimem_*` strobes from the debug slave's system-clock half. The block sequences each access as a small state machine, returns read data to the JTAG side on `MonDReg` with the `monitor_ready`/`monitor_error` status flags, and stalls the CPU with `avs_waitrequest`.

---
 rtl/cpu_debug_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_debug_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_mem_arbiter.sv
// rtl/cpu_debug_mem_arbiter.sv - debug-monitor RAM arbiter between the JTAG debug path and the CPU Avalon slave
//
// Purpose: shares one single-port 2^ADDR_W x 32 RAM between JTAG ocimem commands
// (one-deep pending register, auto-incrementing pointer) and CPU debug-memory
// accesses, alternating grants under contention.
//
// Ports:
//   clk, reset_n                      system clock, asynchronous active-low reset
//   jdo, take_*_ocimem_*              JTAG command word and command strobes
//   avs_*                             CPU debug-memory slave (waitrequest stalls the CPU)
//   ram_addr/wren/byteen/wdata/rdata  RAM port, read data one cycle after address
//   MonDReg, monitor_ready/error      JTAG read data and command status
module cpu_debug_mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT_J,
    S_WAIT_J,
    S_GNT_C,
    S_WAIT_C
  } state_e;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

  state_e            state_q, state_d;
  logic              jpend_q, jpend_d;
  logic              jwrite_q, jwrite_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic [31:0]       jdata_q, jdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic              any_strobe;
  logic              jbusy;
  logic              accept;
  logic              new_access;
  logic              jreq;
  logic              creq;
  logic [ADDR_W-1:0] jdo_addr;
  logic              unused_jdo;

  assign jdo_addr   = jdo[ADDR_W+1:2];
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  // The slot frees up in GNT_J (jpend clears that cycle), so a strobe landing
  // there is taken; a read still waiting for its data blocks new commands.
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign jbusy      = (jpend_q && (state_q != S_GNT_J)) || (state_q == S_WAIT_J);
  assign accept     = any_strobe && !jbusy;
  assign new_access = accept && (take_action_ocimem_b || take_no_action_ocimem_a ||
                                 (take_action_ocimem_a && jdo[35]));
  // A freshly accepted strobe competes in IDLE the same cycle it is latched.
  assign jreq       = jpend_q || new_access;
  assign creq       = avs_read || avs_write;

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

  always_comb begin
    state_d         = state_q;
    jpend_d         = jpend_q;
    jwrite_d        = jwrite_q;
    jaddr_d         = jaddr_q;
    jdata_d         = jdata_q;
    ptr_d           = ptr_q;
    last_grant_d    = last_grant_q;
    mon_dreg_d      = mon_dreg_q;
    ready_d         = ready_q;
    error_d         = error_q;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    ram_addr        = '0;
    ram_wren        = 1'b0;
    ram_byteen      = '0;
    ram_wdata       = '0;

    case (state_q)
      S_IDLE: begin
        if (jreq && (!creq || (last_grant_q == GRANT_CPU))) begin
          state_d      = S_GNT_J;
          last_grant_d = GRANT_JTAG;
        end else if (creq) begin
          state_d      = S_GNT_C;
          last_grant_d = GRANT_CPU;
        end
      end
      S_GNT_J: begin
        ram_addr   = jaddr_q;
        ram_wren   = jwrite_q;
        ram_byteen = 4'hF;
        ram_wdata  = jdata_q;
        jpend_d    = 1'b0;
        if (jwrite_q) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_J;
        end
      end
      S_WAIT_J: begin
        mon_dreg_d = ram_rdata;
        ready_d    = 1'b1;
        state_d    = S_IDLE;
      end
      S_GNT_C: begin
        ram_addr   = avs_address;
        ram_byteen = avs_byteenable;
        ram_wdata  = avs_writedata;
        // Writes without debugaccess still complete, they just never reach the RAM.
        ram_wren   = avs_write && avs_debugaccess;
        if (avs_write) begin
          avs_waitrequest = 1'b0;
          state_d         = S_IDLE;
        end else begin
          state_d = S_WAIT_C;
        end
      end
      S_WAIT_C: begin
        avs_readdata    = ram_rdata;
        avs_waitrequest = 1'b0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Evaluated after the FSM so a command accepted in GNT_J re-arms jpend
    // and keeps monitor_ready low over the completing write.
    if (any_strobe) begin
      if (jbusy) begin
        error_d = 1'b1;
      end else if (take_action_ocimem_a) begin
        ptr_d   = jdo_addr;
        error_d = 1'b0;
        if (jdo[35]) begin
          jaddr_d  = jdo_addr;
          jwrite_d = 1'b0;
          jpend_d  = 1'b1;
          ready_d  = 1'b0;
        end
      end else if (take_action_ocimem_b) begin
        jaddr_d  = ptr_q;
        jdata_d  = jdo[34:3];
        jwrite_d = 1'b1;
        jpend_d  = 1'b1;
        ready_d  = 1'b0;
        ptr_d    = ptr_q + ADDR_W'(1);
      end else begin
        jaddr_d  = ptr_q;
        jwrite_d = 1'b0;
        jpend_d  = 1'b1;
        ready_d  = 1'b0;
        ptr_d    = ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      jpend_q      <= 1'b0;
      jwrite_q     <= 1'b0;
      jaddr_q      <= '0;
      jdata_q      <= '0;
      ptr_q        <= '0;
      last_grant_q <= GRANT_CPU;
      mon_dreg_q   <= '0;
      ready_q      <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      jpend_q      <= jpend_d;
      jwrite_q     <= jwrite_d;
      jaddr_q      <= jaddr_d;
      jdata_q      <= jdata_d;
      ptr_q        <= ptr_d;
      last_grant_q <= last_grant_d;
      mon_dreg_q   <= mon_dreg_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_cpu_debug_mem_arbiter.sv
// tb/tb_cpu_debug_mem_arbiter.sv - scoreboard bench for cpu_debug_mem_arbiter
module tb_cpu_debug_mem_arbiter;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write, avs_debugaccess;
  logic [31:0] avs_writedata, avs_readdata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  always #5 clk = ~clk;

  cpu_debug_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_debugaccess(avs_debugaccess), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .ram_addr(ram_addr), .ram_wren(ram_wren),
    .ram_byteen(ram_byteen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'h5A, b, ~b, b ^ 8'h3C};
  endfunction

  // RAM behind the arbiter: registered read, byte-lane writes
  logic [31:0] mem [0:255];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  // reference model and scoreboard
  logic [31:0] exp_mem [0:255];
  logic [7:0]  ptr;
  logic [43:0] wr_q [$];   // {byteen, addr, data}
  logic [31:0] crd_q [$];
  logic [32:0] jq [$];     // {is_read, data}
  logic        rdy_prev_mon = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_sample();
    logic [43:0] w;
    logic [32:0] e;
    logic [31:0] c;
    if (reset_n) begin
      if (ram_wren) begin
        chk("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", ram_addr, w[39:32]);
          chk("wr_data", ram_wdata, w[31:0]);
          chk("wr_be", ram_byteen, w[43:40]);
        end
      end
      if (!avs_waitrequest && avs_read) begin
        chk("cpu_rd_expected", crd_q.size() != 0, 1);
        if (crd_q.size() != 0) begin
          c = crd_q.pop_front();
          chk("cpu_rdata", avs_readdata, c);
        end
      end
      if (monitor_ready && !rdy_prev_mon) begin
        chk("jtag_done_expected", jq.size() != 0, 1);
        if (jq.size() != 0) begin
          e = jq.pop_front();
          if (e[32]) chk("mondreg", MonDReg, e[31:0]);
        end
      end
    end
    rdy_prev_mon = monitor_ready;
  endtask

  task automatic step();
    @(negedge clk);
    mon_sample();
    @(posedge clk);
    #1;
  endtask

  // kind 0: ocimem_a, 1: ocimem_b, 2: no_action_ocimem_a; model updated as accepted
  task automatic jset(input int kind, input logic [7:0] a, input logic rd, input logic [31:0] d);
    jdo = '0;
    case (kind)
      0: begin
        jdo[9:2] = a; jdo[35] = rd; take_action_ocimem_a = 1'b1;
        ptr = a;
        if (rd) jq.push_back({1'b1, exp_mem[ptr]});
      end
      1: begin
        jdo[34:3] = d; take_action_ocimem_b = 1'b1;
        wr_q.push_back({4'hF, ptr, d});
        exp_mem[ptr] = d;
        jq.push_back({1'b0, 32'h0});
        ptr = ptr + 8'd1;
      end
      default: begin
        take_no_action_ocimem_a = 1'b1;
        jq.push_back({1'b1, exp_mem[ptr]});
        ptr = ptr + 8'd1;
      end
    endcase
  endtask

  task automatic jclr();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jcmd(input int kind, input logic [7:0] a, input logic rd, input logic [31:0] d);
    jset(kind, a, rd, d);
    step();
    jclr();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!monitor_ready && n < 10) begin
      step();
      n++;
    end
    chk("ready_wait", monitor_ready, 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_ready", monitor_ready, 1);
    chk("rst_error", monitor_error, 0);
    chk("rst_waitreq", avs_waitrequest, 1);
    chk("rst_readdata", avs_readdata, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_addr, 0);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    avs_debugaccess = dbg; avs_write = 1'b1;
    if (dbg) begin
      wr_q.push_back({be, a, d});
      for (int b = 0; b < 4; b++)
        if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    chk("cw_wait_idle", avs_waitrequest, 1);
    step();
    chk("cw_waitreq", avs_waitrequest, 0);
    chk("cw_wren", ram_wren, dbg);
    step();
    avs_write = 1'b0;
    avs_debugaccess = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    avs_address = a; avs_read = 1'b1;
    crd_q.push_back(exp_mem[a]);
    chk("cr_wait_idle", avs_waitrequest, 1);
    step();
    chk("cr_wait_gnt", avs_waitrequest, 1);
    step();
    chk("cr_wait_done", avs_waitrequest, 0);
    step();
    avs_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int jdone, cdone, jiss, ciss, wlow, ev;
    logic rdy_prev;
    logic [7:0] got;

    reset_n = 1'b0;
    jdo = '0;
    jclr();
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0; avs_debugaccess = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    ptr = 8'h00;

    // reset values, then reset asserted during a CPU write grant
    repeat (3) step();
    check_reset_vals();
    reset_n = 1'b1;
    step();
    check_reset_vals();
    avs_address = 8'h30; avs_writedata = 32'hCAFEF00D; avs_byteenable = 4'hF;
    avs_debugaccess = 1'b1; avs_write = 1'b1;
    step();
    chk("gntc_wren", ram_wren, 1);
    chk("gntc_waitreq", avs_waitrequest, 0);
    reset_n = 1'b0; avs_write = 1'b0; avs_debugaccess = 1'b0;
    #1;
    chk("rst_abort_wren", ram_wren, 0);
    chk("rst_abort_waitreq", avs_waitrequest, 1);
    step(); step();
    reset_n = 1'b1;
    step();
    check_reset_vals();
    chk("rst_no_write", mem[8'h30], exp_mem[8'h30]);

    // contention: JTAG reads from pointer 0 against back-to-back CPU reads of 0x20
    jdone = 0; cdone = 0; wlow = 0; ev = 0;
    avs_address = 8'h20; avs_read = 1'b1;
    crd_q.push_back(exp_mem[8'h20]);
    ciss = 1;
    jset(2, 8'h00, 1'b0, 32'h0);
    jiss = 1;
    rdy_prev = 1'b1;
    for (int cyc = 0; cyc < 80 && (jdone < 4 || cdone < 4); cyc++) begin
      step();
      jclr();
      if (monitor_ready && !rdy_prev) begin
        got = "J";
        chk("grant_order", got, (ev % 2 == 0) ? 8'h4A : 8'h43);
        ev++; jdone++;
        if (jiss < 4) begin
          jset(2, 8'h00, 1'b0, 32'h0);
          jiss++;
        end
      end
      rdy_prev = monitor_ready;
      if (!avs_waitrequest) begin
        got = "C";
        chk("grant_order", got, (ev % 2 == 0) ? 8'h4A : 8'h43);
        ev++; cdone++; wlow++;
        if (ciss < 4) begin
          crd_q.push_back(exp_mem[8'h20]);
          ciss++;
        end
      end
    end
    chk("contention_j_done", jdone, 4);
    chk("contention_c_done", cdone, 4);
    chk("waitreq_low_cycles", wlow, 4);
    step();
    avs_read = 1'b0;
    step(); step();

    // JTAG round trip at 0x10
    jcmd(0, 8'h10, 1'b0, 32'h0);
    chk("a_noread_ready", monitor_ready, 1);
    chk("a_noread_wren", ram_wren, 0);
    step();
    jcmd(1, 8'h00, 1'b0, 32'hDEADBEEF);
    chk("jw_ready_clr", monitor_ready, 0);
    chk("jw_wren", ram_wren, 1);
    chk("jw_addr", ram_addr, 8'h10);
    step();
    chk("jw_ready_set", monitor_ready, 1);
    chk("jw_ram", mem[8'h10], 32'hDEADBEEF);
    jcmd(0, 8'h10, 1'b1, 32'h0);
    step();
    chk("jr_ready_busy", monitor_ready, 0);
    step();
    chk("jr_mondreg", MonDReg, 32'hDEADBEEF);
    chk("jr_ready", monitor_ready, 1);

    // pointer wrap 0xFF -> 0x00
    jcmd(0, 8'hFF, 1'b0, 32'h0);
    step();
    jcmd(1, 8'h00, 1'b0, 32'h0BAD0001);
    chk("wrap_addr_ff", ram_addr, 8'hFF);
    wait_ready();
    jcmd(1, 8'h00, 1'b0, 32'h0BAD0002);
    chk("wrap_addr_00", ram_addr, 8'h00);
    wait_ready();
    jcmd(0, 8'h00, 1'b1, 32'h0);
    wait_ready();

    // overrun while the CPU holds the grant
    avs_address = 8'h20; avs_read = 1'b1;
    crd_q.push_back(exp_mem[8'h20]);
    step();
    jset(1, 8'h00, 1'b0, 32'h12345678);
    step();
    jclr();
    take_no_action_ocimem_a = 1'b1;
    chk("ovr_cpu_done", avs_waitrequest, 0);
    step();
    jclr();
    avs_read = 1'b0;
    chk("ovr_error_set", monitor_error, 1);
    chk("ovr_ready_low", monitor_ready, 0);
    wait_ready();
    chk("ovr_error_sticky", monitor_error, 1);
    jcmd(0, 8'h05, 1'b0, 32'h0);
    chk("ovr_error_cleared", monitor_error, 0);
    step();

    // CPU writes: debugaccess gating and byte lanes
    cpu_write(8'h40, 32'h11112222, 4'hF, 1'b0);
    cpu_write(8'h41, 32'hAABBCCDD, 4'b0101, 1'b1);
    cpu_read(8'h40);
    cpu_read(8'h41);
    chk("dbg0_ram_unchanged", mem[8'h40], init_val(8'h40));
    repeat (3) step();

    chk("wr_q_drained", wr_q.size(), 0);
    chk("crd_q_drained", crd_q.size(), 0);
    chk("jq_drained", jq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
